// File: rtl/register_scoreboard_pkg.sv
// Shared types and sizing for the register scoreboard: register index and
// per-register pending-write counter types.
package register_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;

  typedef logic [4:0]       reg_idx_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/register_scoreboard_sb_counter.sv
// Per-register pending long-latency write counter. Increments on issue,
// decrements on writeback, holds when both coincide, and never wraps.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             full,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != MAX) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign busy      = (count_q != '0);
  assign full      = (count_q == MAX);
  // A writeback with nothing pending and no same-cycle issue to absorb it.
  assign underflow = dec && !inc && (count_q == '0);

endmodule

// File: rtl/register_scoreboard.sv
// Scoreboard for long-latency register writes: stalls decode on pending
// sources or a saturated destination counter; sticky error and stall counter.
module register_scoreboard
  import register_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = register_scoreboard_pkg::NUM_REGS,
  parameter int CNT_W    = register_scoreboard_pkg::CNT_W,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  reg_idx_t            id_rs1,
  input  reg_idx_t            id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  reg_idx_t            id_rd,
  input  logic                id_RegWrite,
  input  logic                id_long_latency,
  input  logic                id_flush,
  input  logic                wb_valid,
  input  reg_idx_t            wb_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                sb_error,
  output logic [PERF_W-1:0]   stall_count
);

  logic [NUM_REGS-1:0] busy_vec;
  logic [NUM_REGS-1:0] eff_busy_vec;
  logic [NUM_REGS-1:0] full_vec;
  logic [NUM_REGS-1:0] uf_vec;

  logic id_ok;
  logic src1_busy;
  logic src2_busy;
  logic full_hit;
  logic issue;

  logic              sb_error_d;
  logic              sb_error_q;
  logic [PERF_W-1:0] stall_count_d;
  logic [PERF_W-1:0] stall_count_q;

  // x0 is never tracked: its slot is tied off rather than instantiated.
  assign busy_vec[0]     = 1'b0;
  assign eff_busy_vec[0] = 1'b0;
  assign full_vec[0]     = 1'b0;
  assign uf_vec[0]       = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic             wb_hit;
    logic             inc;
    logic [CNT_W-1:0] cnt;

    assign wb_hit = wb_valid && (wb_rd == reg_idx_t'(r));
    assign inc    = issue && (id_rd == reg_idx_t'(r));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc),
      .dec       (wb_hit),
      .count     (cnt),
      .busy      (busy_vec[r]),
      .full      (full_vec[r]),
      .underflow (uf_vec[r])
    );

    // Write-through: the last pending write retiring this cycle frees the source now.
    assign eff_busy_vec[r] = busy_vec[r] && !(wb_hit && cnt == CNT_W'(1));
  end

  assign id_ok     = id_valid && !id_flush;
  assign src1_busy = id_uses_rs1 && eff_busy_vec[id_rs1];
  assign src2_busy = id_uses_rs2 && eff_busy_vec[id_rs2];
  assign full_hit  = id_RegWrite && id_long_latency && (id_rd != '0) &&
                     full_vec[id_rd] && !(wb_valid && wb_rd == id_rd);
  assign stall     = id_ok && (src1_busy || src2_busy || full_hit);
  assign issue     = id_ok && !stall && id_RegWrite && id_long_latency &&
                     (id_rd != '0);

  always_comb begin
    sb_error_d    = sb_error_q | (|uf_vec);
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != '1) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_error_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      sb_error_q    <= sb_error_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy_mask   = busy_vec;
  assign sb_error    = sb_error_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard; a 4-bit stall counter keeps the
// saturation case reachable in a few cycles.
module tb_register_scoreboard;
  import register_scoreboard_pkg::*;

  localparam int PW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           id_valid;
  reg_idx_t       id_rs1;
  reg_idx_t       id_rs2;
  logic           id_uses_rs1;
  logic           id_uses_rs2;
  reg_idx_t       id_rd;
  logic           id_RegWrite;
  logic           id_long_latency;
  logic           id_flush;
  logic           wb_valid;
  reg_idx_t       wb_rd;
  logic           stall;
  logic [31:0]    busy_mask;
  logic           sb_error;
  logic [PW-1:0]  stall_count;

  int total = 0;
  int bad   = 0;

  register_scoreboard #(.NUM_REGS(32), .CNT_W(2), .PERF_W(PW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_RegWrite     (id_RegWrite),
    .id_long_latency (id_long_latency),
    .id_flush        (id_flush),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .stall           (stall),
    .busy_mask       (busy_mask),
    .sb_error        (sb_error),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_RegWrite = 0; id_long_latency = 0; id_flush = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ll_issue(input reg_idx_t rd);
    idle();
    id_valid = 1; id_RegWrite = 1; id_long_latency = 1; id_rd = rd;
  endtask

  task automatic wb(input reg_idx_t rd);
    idle();
    wb_valid = 1; wb_rd = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    #12;
    chk("rst_busy", busy_mask, 0);
    chk("rst_err", sb_error, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_stall", stall, 0);
    reset = 0;
    tick();

    // Load-use on x5, released by a same-cycle writeback.
    ll_issue(5);
    #1 chk("lu_issue_nostall", stall, 0);
    tick();
    chk("lu_busy5", busy_mask, 32'h0000_0020);
    idle();
    id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1;
    #1 chk("lu_stall", stall, 1);
    wb_valid = 1; wb_rd = 5;
    #1 chk("lu_wb_release", stall, 0);
    tick();
    chk("lu_busy_clear", busy_mask, 0);

    // Issue to x0 is never tracked.
    ll_issue(0);
    tick();
    chk("x0_untracked", busy_mask, 0);

    // Pending x7 read only through an unused source port.
    ll_issue(7);
    tick();
    chk("busy7", busy_mask, 32'h0000_0080);
    idle();
    id_valid = 1; id_rs2 = 7; id_uses_rs2 = 0; id_rs1 = 7; id_uses_rs1 = 0;
    #1 chk("unused_src", stall, 0);
    id_uses_rs2 = 1;
    #1 chk("used_src2", stall, 1);
    idle();
    tick();

    // Saturate x9 at 3; fourth issue stalls unless a writeback frees a slot.
    for (int i = 0; i < 3; i++) begin
      ll_issue(9);
      #1 chk($sformatf("sat_issue%0d", i), stall, 0);
      tick();
    end
    chk("sat_busy", busy_mask, 32'h0000_0280);
    ll_issue(9);
    #1 chk("sat_full_stall", stall, 1);
    wb_valid = 1; wb_rd = 9;
    #1 chk("sat_full_wb", stall, 0);
    tick();
    wb(9);
    tick();
    wb(9);
    tick();
    chk("sat_cnt_ge1", busy_mask, 32'h0000_0280);
    wb(9);
    tick();
    chk("sat_cnt_was3", busy_mask, 32'h0000_0080);

    // Simultaneous issue and writeback to x12 leaves count at 1.
    ll_issue(12);
    tick();
    ll_issue(12);
    wb_valid = 1; wb_rd = 12;
    #1 chk("sim_nostall", stall, 0);
    tick();
    chk("sim_busy12", busy_mask, 32'h0000_1080);
    wb(12);
    tick();
    chk("sim_cnt_was1", busy_mask, 32'h0000_0080);

    // Flush suppresses both the stall and the destination issue.
    idle();
    id_valid = 1; id_rs1 = 7; id_uses_rs1 = 1;
    id_RegWrite = 1; id_long_latency = 1; id_rd = 20; id_flush = 1;
    #1 chk("flush_nostall", stall, 0);
    tick();
    chk("flush_noissue", busy_mask, 32'h0000_0080);
    chk("perf_zero", stall_count, 0);

    // Ten stalled cycles, then drive the counter to saturation.
    id_flush = 0;
    #1 chk("perf_stall_on", stall, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("perf_ten", stall_count, 10);
    for (int i = 0; i < 5; i++) tick();
    chk("perf_max", stall_count, 15);
    tick();
    chk("perf_sat", stall_count, 15);

    // Underflow on x3 is sticky.
    wb(3);
    tick();
    chk("uf_set", sb_error, 1);
    idle();
    tick();
    chk("uf_sticky", sb_error, 1);
    chk("uf_cnt_zero", busy_mask, 32'h0000_0080);

    // Asynchronous reset mid-cycle, well clear of a rising edge.
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("arst_err", sb_error, 0);
    chk("arst_busy", busy_mask, 0);
    chk("arst_cnt", stall_count, 0);
    reset = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
